// File: rtl/ahbl_sram_slave.sv
// AHB-Lite word-organised SRAM responder: byte/half/word access, misaligned or bad-size -> two-cycle ERROR.
// Latency WAIT_STATES+1 data-phase cycles for OKAY (reads combinational from array), 2 for ERROR; stalls via HREADYOUT.
module ahbl_sram_slave #(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [2:0] WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t          state;
    state_t          state_nxt;

    logic [31:0]     mem [0:(1<<AW)-1];

    logic [AW-1:0]   word_q;
    logic [1:0]      ofs_q;
    logic [1:0]      size_q;
    logic            write_q;
    logic [2:0]      cnt_q;

    logic            can_accept;
    logic            accept;
    logic            legal;
    logic [3:0]      be;
    logic            unused_bits;

    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept     = can_accept && HSEL && HREADY && HTRANS[1];
    assign legal      = (HSIZE == 3'b000) ||
                        ((HSIZE == 3'b001) && !HADDR[0]) ||
                        ((HSIZE == 3'b010) && (HADDR[1:0] == 2'b00));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (accept) begin
                    if (!legal)
                        state_nxt = S_ERR1;
                    else if (WAIT_STATES > 0)
                        state_nxt = S_WAIT;
                    else
                        state_nxt = S_DATA;
                end
            end
            S_WAIT:  state_nxt = (cnt_q == 3'd0) ? S_DATA : S_WAIT;
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        HRDATA    = 32'd0;
        case (state)
            S_WAIT: HREADYOUT = 1'b0;
            S_DATA: if (!write_q) HRDATA = mem[word_q];
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
            end
            S_ERR2: HRESP = 2'b01;
            default: ;
        endcase
    end

    // Address-phase capture; clearing write_q on reset drops any pending write.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            word_q  <= '0;
            ofs_q   <= 2'b00;
            size_q  <= 2'b00;
            write_q <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            if (accept) begin
                word_q  <= HADDR[AW+1:2];
                ofs_q   <= HADDR[1:0];
                size_q  <= HSIZE[1:0];
                write_q <= HWRITE;
            end
            if (accept && legal)
                cnt_q <= WS_M1;
            else if ((state == S_WAIT) && (cnt_q != 3'd0))
                cnt_q <= cnt_q - 3'd1;
        end
    end

    always_comb begin
        be = 4'b1111;
        case (size_q)
            2'b00:   be = 4'b0001 << ofs_q;
            2'b01:   be = ofs_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Write commits on the edge leaving DATA so a following read sees it without a stall.
    always_ff @(posedge HCLK) begin
        if ((state == S_DATA) && write_q) begin
            for (int n = 0; n < 4; n++) begin
                if (be[n])
                    mem[word_q][8*n +: 8] <= HWDATA[8*n +: 8];
            end
        end
    end

endmodule
